// File: rtl/ula_sequencial.sv
// ula_sequencial: handshaked RISC-V integer ALU with registered result/flags.
//   Non-mul ops complete in one cycle (IDLE -> DONE). With ULA_MUL_EN defined,
//   op 1011 runs a shift-add multiplier for WIDTH cycles in EXEC. Without it,
//   1011 is treated like any other invalid op (result 0, flags 0).
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     request handshake; A, B, ULAControl latched on accept
//   out_valid / out_ready   response handshake; result/flags held while stalled
//   result [WIDTH-1:0]      registered result
//   flags  [3:0]            {Negative, Overflow, Carry, Zero}
// Configuration macro: ULA_MUL_EN
module ula_sequencial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ULAControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_alu_result;
    logic [3:0]       w_alu_flags;
    logic             w_nz_en;
    logic             w_z_only;
    logic [1:0]       w_vc;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_sum     = {1'b0, A} + {1'b0, B};
    // Bit WIDTH of the difference is the unsigned borrow (A < B).
    assign w_diff    = {1'b0, A} - {1'b0, B};
    assign w_shamt   = B[SHW-1:0];
    assign w_add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1]  != A[WIDTH-1]);
    assign w_sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

`ifdef ULA_MUL_EN
    assign w_is_mul = (ULAControl == 4'b1011);
`else
    assign w_is_mul = 1'b0;
`endif

    // Single-cycle ops; flags assembled from per-op enables after the case.
    always_comb begin
        w_alu_result = '0;
        w_nz_en      = 1'b0;
        w_z_only     = 1'b0;
        w_vc         = 2'b00;
        case (ULAControl)
            4'b0000: begin w_alu_result = w_diff[WIDTH-1:0]; w_nz_en = 1'b1; w_vc = {w_sub_ovf, w_diff[WIDTH]}; end
            4'b0001: begin w_alu_result = A ^ B;             w_nz_en = 1'b1; end
            4'b0010: begin w_alu_result = w_sum[WIDTH-1:0];  w_nz_en = 1'b1; w_vc = {w_add_ovf, w_sum[WIDTH]}; end
            4'b0011: begin w_alu_result = A >> w_shamt;      w_nz_en = 1'b1; end
            4'b0100: begin w_alu_result = w_diff[WIDTH-1:0]; w_z_only = 1'b1; end
            4'b0101: begin w_alu_result = A & B;             w_nz_en = 1'b1; end
            4'b0110: begin w_alu_result = A | B;             w_nz_en = 1'b1; end
            4'b0111: begin w_alu_result = A << w_shamt;      w_nz_en = 1'b1; end
            4'b1000: begin w_alu_result = $signed(A) >>> w_shamt; w_nz_en = 1'b1; end
            4'b1001: begin
                w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
                w_nz_en      = 1'b1;
            end
            4'b1010: begin w_alu_result = {{(WIDTH-1){1'b0}}, (A < B)}; w_nz_en = 1'b1; end
            default: begin w_alu_result = '0; end
        endcase
        w_alu_flags = {w_nz_en & w_alu_result[WIDTH-1],
                       w_vc,
                       (w_nz_en | w_z_only) & (w_alu_result == '0)};
    end

`ifdef ULA_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [SHW-1:0]   r_cnt;
    logic             w_mul_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

    // One multiplier bit per EXEC cycle; the counter wraps back to 0 on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= A;
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_EXEC) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + SHW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_is_mul ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
`ifdef ULA_MUL_EN
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_result <= w_alu_result;
            r_flags  <= w_alu_flags;
        end
`ifdef ULA_MUL_EN
        else if ((r_state == S_EXEC) && w_mul_last) begin
            r_result <= w_acc_next;
            r_flags  <= {w_acc_next[WIDTH-1], 2'b00, (w_acc_next == '0)};
        end
`endif
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_ula_sequencial.sv
// tb_ula_sequencial: directed vectors for ula_sequencial (WIDTH=32) with a
// scoreboard queue; a negedge monitor checks latency and result/flags per response.
module tb_ula_sequencial;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ULAControl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    ula_sequencial #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ULAControl (ULAControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         chk_res;
        int           acc_cyc;
        int           lat;
        int           id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    logic prev_ov = 1'b0;

    task automatic chk(input string nm, input int id, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s (vec %0d): got %h, expected %h", nm, id, act, expv);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] er, input logic [3:0] ef, input logic cr,
                            input int acc, input int lat, input int id);
        exp_t e;
        e.res = er; e.fl = ef; e.chk_res = cr; e.acc_cyc = acc; e.lat = lat; e.id = id;
        sb.push_back(e);
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected no response at cycle %0d", cyc);
                end else begin
                    chk("latency", sb[0].id, W'(cyc - sb[0].acc_cyc), W'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.chk_res) chk("result", mon_e.id, result, mon_e.res);
                chk("flags", mon_e.id, W'(flags), W'(mon_e.fl));
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [3:0] ef, input logic cr,
                         input int lat, input int id, output int acc);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b; ULAControl = op;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout (vec %0d): got in_ready=0, expected 1 within 200 cycles", id);
            acc = -1;
        end else begin
            acc = cyc;
            push_exp(er, ef, cr, acc, lat, id);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; ULAControl = 4'($urandom);
    endtask

    task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [3:0] ef, input int id);
        int acc;
        issue(op, a, b, er, ef, 1'b1, 1, id, acc);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ULAControl = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready",  0, W'(in_ready),  W'(1));
        chk("reset_out_valid", 0, W'(out_valid), W'(0));
        chk("reset_result",    0, result,        '0);
        chk("reset_flags",     0, W'(flags),     W'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        run(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1100, 1);
        run(4'b0000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1010, 2);
        run(4'b0100, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0001, 3);
        run(4'b1000, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b1000, 4);
        run(4'b1010, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 5);
        run(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0011, 6);
        run(4'b0000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0100, 7);
        run(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 8);
        run(4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 9);
        run(4'b0110, 32'h0000F0F0, 32'h0F000000, 32'h0F00F0F0, 4'b0000, 10);
        run(4'b0011, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 11);
        run(4'b0111, 32'h00000001, 32'hFFFFFFE4, 32'h00000010, 4'b0000, 12);
        run(4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 13);
        run(4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0001, 14);
        run(4'b0000, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0001, 15);
        run(4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 4'b0000, 16);
        run(4'b1100, 32'h12345678, 32'h00000001, 32'h00000000, 4'b0000, 17);
        // beq flags must stay Zero-only even where sub would set N and C.
        issue(4'b0100, 32'h00000000, 32'h00000001, 32'h0, 4'b0000, 1'b0, 1, 18, a1);

        // Back-to-back requests: one op every two cycles.
        issue(4'b0010, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1'b1, 1, 19, a1);
        issue(4'b0001, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 4'b0001, 1'b1, 1, 20, a2);
        chk("throughput", 20, W'(a2 - a1), W'(2));

        // Backpressure with a request held during the stall.
        drain();
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1100, 1'b1, 1, 21, a1);
        in_valid = 1'b1; A = 32'hF0F0F0F0; B = 32'h0F0F0F0F; ULAControl = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 21, W'(out_valid), W'(1));
            chk("stall_in_ready",  21, W'(in_ready),  W'(0));
            chk("stall_result",    21, result,        32'h80000000);
            chk("stall_flags",     21, W'(flags),     W'(4'b1100));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_stall_in_ready",  22, W'(in_ready),  W'(1));
        chk("post_stall_out_valid", 22, W'(out_valid), W'(0));
        push_exp(32'hFFFFFFFF, 4'b1000, 1'b1, cyc, 1, 22);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

`ifdef ULA_MUL_EN
        issue(4'b1011, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b1000, 1'b1, 33, 30, a1);
        issue(4'b1011, 32'h80000000, 32'h00000002, 32'h00000000, 4'b0001, 1'b1, 33, 31, a1);
        issue(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b1, 33, 32, a1);
        issue(4'b1011, 32'h00000007, 32'h00000009, 32'h0000003F, 4'b0000, 1'b1, 33, 33, a1);
        drain();
        // Reset in the middle of a multiply discards it.
        issue(4'b1011, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b1000, 1'b1, 33, 34, a1);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midexec_in_ready",  34, W'(in_ready),  W'(1));
        chk("midexec_out_valid", 34, W'(out_valid), W'(0));
        chk("midexec_result",    34, result,        '0);
        chk("midexec_flags",     34, W'(flags),     W'(0));
        issue(4'b1011, 32'h00000003, 32'h00000005, 32'h0000000F, 4'b0000, 1'b1, 33, 35, a1);
        drain();
`else
        run(4'b1011, 32'h0000FFFF, 32'h00010001, 32'h00000000, 4'b0000, 30);
        run(4'b1011, 32'h00000003, 32'h00000005, 32'h00000000, 4'b0000, 31);
`endif

        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
